uart_packet_tx: RTL and testbench

//  Parametrised FPGA-to-PC packet transmitter. Queues bytes from a valid/ready stream,

---
 rtl/uart_packet_tx_pkg.sv | 18 +
 rtl/uart_packet_tx_if.sv | 23 ++
 rtl/uart_packet_tx_sync_fifo.sv | 47 ++++
 rtl/uart_packet_tx.sv | 173 +++++++++++++++++
 tb/tb_uart_packet_tx.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_packet_tx_pkg.sv
// Shared types and helpers for the framed UART packet transmitter.
// Frame layout on the wire: SOF | LEN | PAYLOAD[LEN] | CSUM.
package uart_pkt_pkg;

  typedef enum logic [2:0] {IDLE, SOF, LEN, PAYLOAD, CSUM, GAP} pkt_state_t;

  typedef enum logic {SRC_FIFO, SRC_PATTERN} pkt_src_t;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

  // Pattern length of 0 is sent as 1; anything above the packet limit is clipped to it.
  function automatic logic [7:0] clamp_len(input logic [7:0] len, input logic [7:0] max_len);
    if (len == 8'd0) return 8'd1;
    if (len > max_len) return max_len;
    return len;
  endfunction

endpackage

// File: rtl/uart_packet_tx_if.sv
// Byte-stream input and uart_tx byte handshake of the packet transmitter.
// The slave modport is the transmitter's view; master is the surrounding logic.
interface uart_packet_tx_if;

  logic       s_valid;
  logic [7:0] s_data;
  logic       s_last;
  logic       s_ready;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_done;

  modport master (
    output s_valid, s_data, s_last, tx_done,
    input  s_ready, tx_valid, tx_data
  );

  modport slave (
    input  s_valid, s_data, s_last, tx_done,
    output s_ready, tx_valid, tx_data
  );

endinterface

// File: rtl/uart_packet_tx_sync_fifo.sv
// First-word-fall-through synchronous FIFO; rd_data shows the head entry whenever !empty.
// Pushes while full and pops while empty are dropped; a push and pop together are both honoured.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wr_data;
  end

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/uart_packet_tx.sv
// Packet framer in front of uart_tx: queues stream bytes, emits SOF|LEN|PAYLOAD|CSUM one byte
// at a time, and falls back to incrementing-byte test packets when nothing is queued.
module uart_packet_tx
  import uart_pkt_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned MAX_PAYLOAD = 16,
  parameter int unsigned GAP_CYCLES  = 1000,
  parameter logic [7:0]  SOF_BYTE    = SOF_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  uart_packet_tx_if.slave        bus,
  input  logic                   pattern_en,
  input  logic [7:0]             pattern_len,
  output logic                   busy,
  output logic [15:0]            pkt_count
);

  localparam logic [7:0]         MaxLen  = 8'(MAX_PAYLOAD);
  localparam int unsigned        GapW    = $clog2(GAP_CYCLES + 1);
  localparam logic [GapW-1:0]    GapLast = GapW'(GAP_CYCLES - 1);

  // Write side
  logic       data_full, data_empty, len_full, len_empty;
  logic [7:0] data_rd, len_rd;
  logic       accept, close_pkt, data_pop, len_pop;
  logic [7:0] wr_cnt_q;

  assign bus.s_ready = rst_n & ~data_full & ~len_full;
  assign accept      = bus.s_valid & bus.s_ready;
  assign close_pkt   = bus.s_last | ((wr_cnt_q + 8'd1) == MaxLen);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt_q <= 8'd0;
    end else if (accept) begin
      wr_cnt_q <= close_pkt ? 8'd0 : wr_cnt_q + 8'd1;
    end
  end

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_data_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (accept),
    .wr_data (bus.s_data),
    .pop     (data_pop),
    .rd_data (data_rd),
    .full    (data_full),
    .empty   (data_empty)
  );

  // LEN is pushed only with a packet's final byte, so its payload is already in the data FIFO.
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_len_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (accept & close_pkt),
    .wr_data (wr_cnt_q + 8'd1),
    .pop     (len_pop),
    .rd_data (len_rd),
    .full    (len_full),
    .empty   (len_empty)
  );

  // Read side
  pkt_state_t      state_q;
  pkt_src_t        src_q;
  logic            wait_q;
  logic            tx_valid_q;
  logic [7:0]      tx_data_q, len_q, pay_cnt_q, csum_q, seed_q;
  logic [GapW-1:0] gap_cnt_q;
  logic [15:0]     pkt_count_q;
  logic [7:0]      pat_len, pay_byte;

  assign pat_len  = clamp_len(pattern_len, MaxLen);
  assign pay_byte = (src_q == SRC_FIFO) ? data_rd : seed_q;
  assign len_pop  = (state_q == IDLE) & ~len_empty;
  assign data_pop = (state_q == PAYLOAD) & ~wait_q & (src_q == SRC_FIFO);

  // wait_q low = SEND sub-phase (one-cycle tx_valid), high = WAIT for tx_done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      src_q       <= SRC_FIFO;
      wait_q      <= 1'b0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= 8'd0;
      len_q       <= 8'd0;
      pay_cnt_q   <= 8'd0;
      csum_q      <= 8'd0;
      seed_q      <= 8'd0;
      gap_cnt_q   <= '0;
      pkt_count_q <= 16'd0;
    end else begin
      tx_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (!len_empty) begin
            len_q     <= len_rd;
            csum_q    <= len_rd;
            src_q     <= SRC_FIFO;
            pay_cnt_q <= 8'd0;
            wait_q    <= 1'b0;
            state_q   <= SOF;
          end else if (pattern_en) begin
            len_q     <= pat_len;
            csum_q    <= pat_len;
            src_q     <= SRC_PATTERN;
            pay_cnt_q <= 8'd0;
            wait_q    <= 1'b0;
            state_q   <= SOF;
          end
        end
        SOF: begin
          if (!wait_q) begin
            tx_valid_q <= 1'b1;
            tx_data_q  <= SOF_BYTE;
            wait_q     <= 1'b1;
          end else if (bus.tx_done) begin
            wait_q  <= 1'b0;
            state_q <= LEN;
          end
        end
        LEN: begin
          if (!wait_q) begin
            tx_valid_q <= 1'b1;
            tx_data_q  <= len_q;
            wait_q     <= 1'b1;
          end else if (bus.tx_done) begin
            wait_q  <= 1'b0;
            state_q <= PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (!wait_q) begin
            tx_valid_q <= 1'b1;
            tx_data_q  <= pay_byte;
            csum_q     <= csum_q ^ pay_byte;
            pay_cnt_q  <= pay_cnt_q + 8'd1;
            if (src_q == SRC_PATTERN) seed_q <= seed_q + 8'd1;
            wait_q     <= 1'b1;
          end else if (bus.tx_done) begin
            wait_q  <= 1'b0;
            state_q <= (pay_cnt_q == len_q) ? CSUM : PAYLOAD;
          end
        end
        CSUM: begin
          if (!wait_q) begin
            tx_valid_q <= 1'b1;
            tx_data_q  <= csum_q;
            wait_q     <= 1'b1;
          end else if (bus.tx_done) begin
            wait_q      <= 1'b0;
            gap_cnt_q   <= '0;
            pkt_count_q <= pkt_count_q + 16'd1;
            state_q     <= GAP;
          end
        end
        GAP: begin
          if (gap_cnt_q == GapLast) state_q <= IDLE;
          else gap_cnt_q <= gap_cnt_q + 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.tx_valid = tx_valid_q;
  assign bus.tx_data  = tx_data_q;
  assign busy         = (state_q != IDLE);
  assign pkt_count    = pkt_count_q;

endmodule

// File: tb/tb_uart_packet_tx.sv
// Bench for uart_packet_tx: models uart_tx (tx_done 20 cycles after tx_valid) and checks every
// transmitted byte against a queue of expected frames built from the stimulus.
module tb_uart_packet_tx;

  localparam int unsigned GapCycles = 50;

  logic        clk_100mhz = 1'b0;
  logic        rst_n;
  logic        pattern_en;
  logic [7:0]  pattern_len;
  logic        busy;
  logic [15:0] pkt_count;
  logic        link_stall;

  uart_packet_tx_if bus();

  uart_packet_tx #(
    .FIFO_DEPTH  (16),
    .MAX_PAYLOAD (16),
    .GAP_CYCLES  (GapCycles),
    .SOF_BYTE    (8'hA5)
  ) dut (
    .clk         (clk_100mhz),
    .rst_n       (rst_n),
    .bus         (bus),
    .pattern_en  (pattern_en),
    .pattern_len (pattern_len),
    .busy        (busy),
    .pkt_count   (pkt_count)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         last_done_cyc = 0;
  int         done_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  int         obs_cyc_q[$];
  logic [7:0] seed = 8'd0;

  always @(posedge clk_100mhz) cyc <= cyc + 1;

  // uart_tx model; link_stall freezes the byte in flight.
  always @(negedge clk_100mhz) begin
    if (!rst_n) begin
      done_cnt    <= 0;
      bus.tx_done <= 1'b0;
    end else begin
      bus.tx_done <= (done_cnt == 1) && !link_stall;
      if ((done_cnt == 1) && !link_stall) last_done_cyc <= cyc;
      if (bus.tx_valid) done_cnt <= 20;
      else if ((done_cnt != 0) && !link_stall) done_cnt <= done_cnt - 1;
    end
  end

  always @(negedge clk_100mhz) begin
    if (rst_n && bus.tx_valid) begin
      obs_q.push_back(bus.tx_data);
      obs_cyc_q.push_back(cyc);
    end
  end

  function automatic void exp_packet(input logic [7:0] pl[$]);
    logic [7:0] cs;
    cs = 8'(pl.size());
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'(pl.size()));
    foreach (pl[i]) begin
      exp_q.push_back(pl[i]);
      cs ^= pl[i];
    end
    exp_q.push_back(cs);
  endfunction

  task automatic push_byte(input logic [7:0] d, input logic last, output int acc_cyc);
    int n = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = last;
    while (!bus.s_ready && n < 3000) begin
      @(negedge clk_100mhz);
      n++;
    end
    checks++;
    if (!bus.s_ready) begin
      failures++;
      $display("FAIL push_timeout data=%02h s_ready=0 required=1", d);
    end
    @(posedge clk_100mhz);
    @(negedge clk_100mhz);
    acc_cyc     = cyc;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic next_obs(output logic [7:0] b, output int c, output bit ok);
    int n = 0;
    while (obs_q.size() == 0 && n < 2000) begin
      @(negedge clk_100mhz);
      n++;
    end
    ok = (obs_q.size() != 0);
    b  = 8'h00;
    c  = 0;
    if (ok) begin
      b = obs_q.pop_front();
      c = obs_cyc_q.pop_front();
    end
  endtask

  task automatic wait_idle(output bit ok);
    int n = 0;
    while (busy && n < 3000) begin
      @(negedge clk_100mhz);
      n++;
    end
    ok = !busy;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk_100mhz);
    checks++; if (bus.tx_valid !== 1'b0) begin failures++;
      $display("FAIL reset_tx_valid got=%b exp=0", bus.tx_valid); end
    checks++; if (bus.tx_data !== 8'h00) begin failures++;
      $display("FAIL reset_tx_data got=%02h exp=00", bus.tx_data); end
    checks++; if (busy !== 1'b0) begin failures++;
      $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (pkt_count !== 16'd0) begin failures++;
      $display("FAIL reset_pkt_count got=%0d exp=0", pkt_count); end
    checks++; if (bus.s_ready !== 1'b0) begin failures++;
      $display("FAIL reset_s_ready got=%b exp=0", bus.s_ready); end
    rst_n = 1'b1;
    @(negedge clk_100mhz);
    checks++; if (bus.s_ready !== 1'b1) begin failures++;
      $display("FAIL post_reset_s_ready got=%b exp=1", bus.s_ready); end
  endtask

  task automatic test_single;
    logic [7:0] pl[$];
    logic [7:0] b, e;
    int acc, c, idx;
    bit ok;
    pl.push_back(8'h11); pl.push_back(8'h22); pl.push_back(8'h33);
    exp_packet(pl);
    push_byte(8'h11, 1'b0, acc);
    push_byte(8'h22, 1'b0, acc);
    push_byte(8'h33, 1'b1, acc);
    idx = 0;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      next_obs(b, c, ok);
      checks++;
      if (!ok || b !== e) begin
        failures++;
        $display("FAIL single_byte%0d got=%02h exp=%02h seen=%0b", idx, b, e, ok);
        if (!ok) begin exp_q.delete(); break; end
      end
      // Last byte accepted, one IDLE decision cycle, one SOF send cycle.
      if (idx == 0) begin
        checks++;
        if (c - acc != 2) begin failures++;
          $display("FAIL single_latency got=%0d exp=2", c - acc); end
      end
      idx++;
    end
    wait_idle(ok);
    checks++;
    if (!ok || pkt_count !== 16'd1) begin failures++;
      $display("FAIL single_pkt_count got=%0d exp=1 idle=%0b", pkt_count, ok); end
  endtask

  task automatic test_pattern;
    logic [7:0] pl[$];
    logic [7:0] b, e;
    int c, idx;
    bit ok;
    for (int p = 0; p < 2; p++) begin
      pl.delete();
      for (int i = 0; i < 4; i++) begin pl.push_back(seed); seed++; end
      exp_packet(pl);
    end
    pattern_len = 8'd4;
    pattern_en  = 1'b1;
    idx = 0;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      next_obs(b, c, ok);
      checks++;
      if (!ok || b !== e) begin
        failures++;
        $display("FAIL pattern_byte%0d got=%02h exp=%02h seen=%0b", idx, b, e, ok);
        if (!ok) begin exp_q.delete(); break; end
      end
      if (idx == 7) begin
        // Dropping enable after the second SOF must not truncate that packet.
        pattern_en = 1'b0;
        // CSUM done, GapCycles of GAP, one IDLE decision, one SOF send.
        checks++;
        if (c - last_done_cyc != int'(GapCycles) + 3) begin failures++;
          $display("FAIL pattern_gap got=%0d exp=%0d", c - last_done_cyc, GapCycles + 3); end
      end
      idx++;
    end
    wait_idle(ok);
    checks++;
    if (!ok || pkt_count !== 16'd3) begin failures++;
      $display("FAIL pattern_pkt_count got=%0d exp=3 idle=%0b", pkt_count, ok); end
  endtask

  task automatic test_max_payload;
    logic [7:0] pl[$];
    logic [7:0] b, e;
    int acc, c, idx;
    bit ok;
    for (int i = 0; i < 16; i++) pl.push_back(8'h40 + 8'(i));
    exp_packet(pl);
    pl.delete();
    for (int i = 16; i < 20; i++) pl.push_back(8'h40 + 8'(i));
    exp_packet(pl);
    for (int i = 0; i < 20; i++) push_byte(8'h40 + 8'(i), (i == 19), acc);
    idx = 0;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      next_obs(b, c, ok);
      checks++;
      if (!ok || b !== e) begin
        failures++;
        $display("FAIL maxpay_byte%0d got=%02h exp=%02h seen=%0b", idx, b, e, ok);
        if (!ok) begin exp_q.delete(); break; end
      end
      idx++;
    end
    wait_idle(ok);
    checks++;
    if (!ok || pkt_count !== 16'd5) begin failures++;
      $display("FAIL maxpay_pkt_count got=%0d exp=5 idle=%0b", pkt_count, ok); end
  endtask

  task automatic test_backpressure;
    logic [7:0] pl[$];
    logic [7:0] b, e;
    int acc, c, idx;
    bit ok, took;
    for (int i = 0; i < 16; i++) pl.push_back(8'h80 + 8'(i));
    exp_packet(pl);
    pl.delete();
    pl.push_back(8'h99);
    exp_packet(pl);
    link_stall = 1'b1;
    for (int i = 0; i < 16; i++) push_byte(8'h80 + 8'(i), 1'b0, acc);
    checks++;
    if (bus.s_ready !== 1'b0) begin failures++;
      $display("FAIL full_s_ready got=%b exp=0", bus.s_ready); end
    bus.s_valid = 1'b1;
    bus.s_data  = 8'h99;
    bus.s_last  = 1'b1;
    took = 1'b0;
    repeat (30) begin
      @(negedge clk_100mhz);
      if (bus.s_ready) took = 1'b1;
    end
    checks++;
    if (took) begin failures++;
      $display("FAIL full_blocks_input got=accepted exp=blocked"); end
    link_stall = 1'b0;
    if (!took) push_byte(8'h99, 1'b1, acc);
    else begin bus.s_valid = 1'b0; bus.s_last = 1'b0; end
    idx = 0;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      next_obs(b, c, ok);
      checks++;
      if (!ok || b !== e) begin
        failures++;
        $display("FAIL drain_byte%0d got=%02h exp=%02h seen=%0b", idx, b, e, ok);
        if (!ok) begin exp_q.delete(); break; end
      end
      idx++;
    end
    wait_idle(ok);
    checks++;
    if (!ok || pkt_count !== 16'd7) begin failures++;
      $display("FAIL drain_pkt_count got=%0d exp=7 idle=%0b", pkt_count, ok); end
  endtask

  task automatic test_priority;
    logic [7:0] pl[$];
    logic [7:0] b, e;
    int acc, c, idx;
    bit ok;
    pl.push_back(8'h01); pl.push_back(8'h02); pl.push_back(8'h03);
    exp_packet(pl);
    pl.delete();
    pl.push_back(8'hC0); pl.push_back(8'hC1);
    exp_packet(pl);
    // pattern_len 0 becomes 1, then 200 clips to 16.
    pl.delete();
    pl.push_back(seed); seed++;
    exp_packet(pl);
    pl.delete();
    for (int i = 0; i < 16; i++) begin pl.push_back(seed); seed++; end
    exp_packet(pl);
    pattern_len = 8'd0;
    push_byte(8'h01, 1'b0, acc);
    push_byte(8'h02, 1'b0, acc);
    push_byte(8'h03, 1'b1, acc);
    push_byte(8'hC0, 1'b0, acc);
    push_byte(8'hC1, 1'b1, acc);
    pattern_en = 1'b1;
    idx = 0;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      next_obs(b, c, ok);
      checks++;
      if (!ok || b !== e) begin
        failures++;
        $display("FAIL priority_byte%0d got=%02h exp=%02h seen=%0b", idx, b, e, ok);
        if (!ok) begin exp_q.delete(); break; end
      end
      if (idx == 11) pattern_len = 8'd200;
      if (idx == 15) pattern_en = 1'b0;
      idx++;
    end
    wait_idle(ok);
    checks++;
    if (!ok || pkt_count !== 16'd11) begin failures++;
      $display("FAIL priority_pkt_count got=%0d exp=11 idle=%0b", pkt_count, ok); end
  endtask

  task automatic test_reset_mid_packet;
    logic [7:0] pl[$];
    logic [7:0] b, e;
    int acc, c, idx;
    bit ok;
    pl.push_back(8'h71); pl.push_back(8'h72); pl.push_back(8'h73);
    exp_packet(pl);
    push_byte(8'h71, 1'b0, acc);
    push_byte(8'h72, 1'b0, acc);
    push_byte(8'h73, 1'b1, acc);
    for (int i = 0; i < 3; i++) begin
      e = exp_q.pop_front();
      next_obs(b, c, ok);
      checks++;
      if (!ok || b !== e) begin failures++;
        $display("FAIL prereset_byte%0d got=%02h exp=%02h seen=%0b", i, b, e, ok); end
    end
    repeat (5) @(negedge clk_100mhz);
    rst_n = 1'b0;
    #1;
    checks++; if (bus.tx_valid !== 1'b0) begin failures++;
      $display("FAIL midreset_tx_valid got=%b exp=0", bus.tx_valid); end
    checks++; if (busy !== 1'b0) begin failures++;
      $display("FAIL midreset_busy got=%b exp=0", busy); end
    checks++; if (pkt_count !== 16'd0) begin failures++;
      $display("FAIL midreset_pkt_count got=%0d exp=0", pkt_count); end
    checks++; if (bus.s_ready !== 1'b0) begin failures++;
      $display("FAIL midreset_s_ready got=%b exp=0", bus.s_ready); end
    repeat (3) @(negedge clk_100mhz);
    rst_n = 1'b1;
    seed  = 8'd0;
    exp_q.delete();
    obs_q.delete();
    obs_cyc_q.delete();
    repeat (200) @(negedge clk_100mhz);
    checks++;
    if (obs_q.size() != 0) begin failures++;
      $display("FAIL postreset_spurious got=%0d bytes exp=0", obs_q.size()); end
    pl.delete();
    pl.push_back(8'h5A);
    exp_packet(pl);
    push_byte(8'h5A, 1'b1, acc);
    idx = 0;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      next_obs(b, c, ok);
      checks++;
      if (!ok || b !== e) begin
        failures++;
        $display("FAIL postreset_byte%0d got=%02h exp=%02h seen=%0b", idx, b, e, ok);
        if (!ok) begin exp_q.delete(); break; end
      end
      idx++;
    end
    wait_idle(ok);
    checks++;
    if (!ok || pkt_count !== 16'd1) begin failures++;
      $display("FAIL postreset_pkt_count got=%0d exp=1 idle=%0b", pkt_count, ok); end
  endtask

  initial begin
    rst_n       = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
    bus.s_last  = 1'b0;
    pattern_en  = 1'b0;
    pattern_len = 8'd0;
    link_stall  = 1'b0;
    test_reset();
    test_single();
    test_pattern();
    test_max_payload();
    test_backpressure();
    test_priority();
    test_reset_mid_packet();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
